// File: rtl/fetch_queue_if.sv
// Handshake bundle between the fetch stage, the fetch queue and the decode stage.
// master = fetch/decode side that drives pushes and pop acceptance; slave = the queue.
interface fetch_queue_if #(
    parameter int unsigned PC_W    = 32,
    parameter int unsigned INSTR_W = 32
);
    logic               push_valid;
    logic [PC_W-1:0]    push_pc;
    logic [INSTR_W-1:0] push_instr;
    logic               push_ready;
    logic               pop_ready;
    logic               pop_valid;
    logic [PC_W-1:0]    pop_pc;
    logic [INSTR_W-1:0] pop_instr;

    modport master (
        output push_valid, push_pc, push_instr, pop_ready,
        input  push_ready, pop_valid, pop_pc, pop_instr
    );

    modport slave (
        input  push_valid, push_pc, push_instr, pop_ready,
        output push_ready, pop_valid, pop_pc, pop_instr
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue between IF and ID: circular buffer with first-word-fall-through,
// single-cycle flush on branch taken, and a saturating count of flushed entries.
module fetch_queue #(
    parameter int unsigned PC_W     = 32,
    parameter int unsigned INSTR_W  = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AF_LEVEL = DEPTH - 1,
    parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    fetch_queue_if.slave      bus,
    output logic [CNT_W-1:0]  count,
    output logic              almost_full,
    output logic [7:0]        flush_drops
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned SUM_W = CNT_W + 9;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            head;
    entry_t            wr_entry;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_nxt;
    logic [SUM_W-1:0]  drops_sum;
    logic              full;
    logic              empty;
    logic              push_fire;
    logic              pop_fire;

    // Handshake status depends on registered state only (plus reset gating on push_ready).
    assign full           = (count == CNT_W'(DEPTH));
    assign empty          = (count == '0);
    assign bus.push_ready = ~full & ~rst;
    assign bus.pop_valid  = ~empty;
    assign push_fire      = bus.push_valid & bus.push_ready;
    assign pop_fire       = bus.pop_valid & bus.pop_ready;

    // Head entry falls through; an empty queue presents a zero bubble.
    assign head          = mem[rd_ptr];
    assign bus.pop_pc    = empty ? '0 : head.pc;
    assign bus.pop_instr = empty ? '0 : head.instr;

    assign wr_entry.pc    = bus.push_pc;
    assign wr_entry.instr = bus.push_instr;

    always_comb begin
        count_nxt = count;
        if (push_fire && !pop_fire) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop_fire && !push_fire) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    assign drops_sum = SUM_W'(flush_drops) + SUM_W'(count);

    // Control state: reset beats flush, flush beats any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
            flush_drops <= '0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
            flush_drops <= (drops_sum > SUM_W'(255)) ? 8'hFF : drops_sum[7:0];
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count       <= count_nxt;
            almost_full <= (count_nxt >= CNT_W'(AF_LEVEL));
        end
    end

    // Storage needs no reset; stale contents are hidden by the empty mask.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push_fire) begin
            mem[wr_ptr] <= wr_entry;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic,
// all compared against a queue-based reference model.
module tb_fetch_queue;
    localparam int unsigned PC_W     = 32;
    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned AF_LEVEL = DEPTH - 1;
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [CNT_W-1:0] count;
    logic             almost_full;
    logic [7:0]       flush_drops;

    fetch_queue_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    fetch_queue #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus),
        .count(count), .almost_full(almost_full), .flush_drops(flush_drops)
    );

    always #5 clk = ~clk;

    ent_t        mq[$];
    int          mdrops;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] popped[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, compare state-derived outputs, advance the model.
    task automatic step(input bit r, input bit f, input bit pv, input logic [31:0] pc,
                        input logic [31:0] instr, input bit pr);
        bit exp_pr;
        bit exp_pv;
        logic [31:0] exp_pc;
        logic [31:0] exp_in;
        rst = r; flush = f;
        bus.push_valid = pv; bus.push_pc = pc; bus.push_instr = instr; bus.pop_ready = pr;
        #1;
        exp_pr = !r && (mq.size() < DEPTH);
        exp_pv = (mq.size() != 0);
        exp_pc = exp_pv ? mq[0].pc : 32'h0;
        exp_in = exp_pv ? mq[0].instr : 32'h0;
        check("push_ready", 32'(bus.push_ready), 32'(exp_pr));
        check("pop_valid", 32'(bus.pop_valid), 32'(exp_pv));
        check("pop_pc", bus.pop_pc, exp_pc);
        check("pop_instr", bus.pop_instr, exp_in);
        check("count", 32'(count), 32'(mq.size()));
        check("almost_full", 32'(almost_full), 32'(mq.size() >= AF_LEVEL));
        check("flush_drops", 32'(flush_drops), 32'(mdrops));
        if (!r && !f && exp_pv && pr) popped.push_back(bus.pop_pc);
        @(posedge clk);
        #1;
        if (r) begin
            mq.delete();
            mdrops = 0;
        end else if (f) begin
            mdrops = (mdrops + mq.size() > 255) ? 255 : mdrops + mq.size();
            mq.delete();
        end else begin
            if (exp_pv && pr) void'(mq.pop_front());
            if (exp_pr && pv) mq.push_back('{pc: pc, instr: instr});
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic push(input logic [31:0] pc);
        step(1'b0, 1'b0, 1'b1, pc, $urandom, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        idle();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        bus.push_valid = 1'b0; bus.push_pc = '0; bus.push_instr = '0; bus.pop_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mq.delete();
        mdrops = 0;

        // Reset state, then push_ready rises once rst drops.
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("rst_push_ready", 32'(bus.push_ready), 32'h0);
        idle();

        // Three pushes with decode frozen.
        push(32'd4); push(32'd8); push(32'd12);
        check("t1_count", 32'(count), 32'd3);
        check("t1_af", 32'(almost_full), 32'd1);
        check("t1_head", bus.pop_pc, 32'd4);
        do_reset();

        // Fill, hold push while full, then one pop frees a slot.
        push(32'd4); push(32'd8); push(32'd12); push(32'd16);
        step(1'b0, 1'b0, 1'b1, 32'd20, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'd20, 32'h0, 1'b0);
        check("t2_full_ready", 32'(bus.push_ready), 32'h0);
        check("t2_full_count", 32'(count), 32'd4);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        check("t2_head", bus.pop_pc, 32'd8);
        check("t2_ready", 32'(bus.push_ready), 32'd1);
        do_reset();

        // Sustained push+pop across pointer wrap.
        popped.delete();
        step(1'b0, 1'b0, 1'b1, 32'd4, $urandom, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b1, 32'(8 + 4 * i), $urandom, 1'b1);
            check("t3_count", 32'(count), 32'd1);
        end
        check("t3_pops", 32'(popped.size()), 32'd20);
        for (int i = 0; i < popped.size(); i++) check("t3_order", popped[i], 32'(4 * (i + 1)));
        do_reset();

        // Flush wins over a simultaneous push and pop.
        push(32'd4); push(32'd8); push(32'd12);
        step(1'b0, 1'b1, 1'b1, 32'd16, 32'hdead, 1'b1);
        check("t4_count", 32'(count), 32'd0);
        check("t4_instr", bus.pop_instr, 32'd0);
        check("t4_drops", 32'(flush_drops), 32'd3);
        check("t4_valid", 32'(bus.pop_valid), 32'd0);
        push(32'd20);
        check("t4_after", 32'(count), 32'd1);

        // Reset mid-operation clears everything including the drop counter.
        push(32'd24);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("t5_count", 32'(count), 32'd0);
        check("t5_valid", 32'(bus.pop_valid), 32'd0);
        check("t5_pc", bus.pop_pc, 32'd0);
        check("t5_af", 32'(almost_full), 32'd0);
        check("t5_drops", 32'(flush_drops), 32'd0);
        idle();
        check("t5_ready", 32'(bus.push_ready), 32'd1);

        // Repeated flushes of a full queue saturate the drop counter.
        for (int n = 0; n < 100; n++) begin
            for (int k = 0; k < DEPTH; k++) push(32'(4 * (k + 1)));
            step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        end
        check("t6_sat", 32'(flush_drops), 32'd255);
        do_reset();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 29) == 0),
                 $urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 2) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction fetch queue that replaces the single-entry IF/ID pipeline register between `IF_Stage` and `ID_Stage`. It buffers up to DEPTH fetched (PC, instruction) pairs so that fetch can run ahead while decode is frozen. A ready/valid handshake governs both sides. Flush on branch-taken discards every buffered entry in one cycle.

## Interface
- `PC_W`, default 32: PC field width.
- `INSTR_W`, default 32: instruction field width.
- `DEPTH`, default 4: entry count; power of 2, ≥2.
- `AF_LEVEL`, default DEPTH-1: occupancy at or above which `almost_full` asserts; range 1..DEPTH.
- `CNT_W`, default $clog2(DEPTH+1): occupancy counter width (derived).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: discard all entries (branch taken in EXE).
- `push_valid` in 1: IF presents a valid fetch.
- `push_pc` in PC_W: PC of the fetched instruction (PC+4 convention, as `IF_Stage` produces).
- `push_instr` in INSTR_W: fetched instruction word.
- `push_ready` out 1: queue can accept a push this cycle; IF freezes when low.
- `pop_ready` in 1: ID consumes the head this cycle (low on freeze/hazard).
- `pop_valid` out 1: head entry valid.
- `pop_pc` out PC_W: head PC; 0 when `pop_valid`=0.
- `pop_instr` out INSTR_W: head instruction; 0 (bubble) when `pop_valid`=0.
- `count` out CNT_W: current occupancy.
- `almost_full` out 1: `count` ≥ AF_LEVEL.
- `flush_drops` out 8: saturating count of entries discarded by flushes since reset.

## Operation
- Storage: circular buffer of DEPTH entries, each holding a PC and an instruction. Read and write pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. Occupancy is held in `count`.
- Handshakes:
  - Push fires when `push_valid & push_ready`.
  - Pop fires when `pop_valid & pop_ready`.
  - `push_ready` = (`count` < DEPTH) & ~`rst`. It is combinational from state only and never depends on `pop_ready`.
  - `pop_valid` = (`count` ≠ 0).
- First-word-fall-through: the head entry is driven continuously on `pop_pc`/`pop_instr`, masked to 0 when the queue is empty.
- Both fire in the same cycle: one write and one read occur, and `count` is unchanged.
- Full queue: `push_ready`=0, so no push is accepted even if a pop fires in the same cycle. There is no pass-through.
- Empty queue: `pop_valid`=0, so `pop_ready` is ignored. A push into an empty queue becomes visible on the next cycle only; there is no bypass.
- Flush:
  - Pointers and `count` go to 0 at the next edge.
  - Any push or pop in that cycle is dropped.
  - `flush_drops` += `count` (pre-flush value), saturating at 255.
- Priority: `rst` > `flush` > push/pop.
- Reset values: `count`=0, pointers=0, `pop_valid`=0, `pop_pc`=0, `pop_instr`=0, `almost_full`=0, `flush_drops`=0, `push_ready`=0 while `rst`=1. Storage contents are don't-care; they are never visible because of the output mask.
- Reset asserted mid-operation discards all entries without incrementing `flush_drops`.

## Timing
- Push to pop latency: 1 cycle. An entry pushed at edge k is presented with `pop_valid`=1 in the cycle after edge k.
- `count` and `almost_full` update at the edge where the handshake fires.
- `push_ready` rises in the first cycle after `rst` deasserts.
- After a flush at edge k: `count`=0 and `pop_valid`=0 in cycle k+1, and a push in cycle k+1 is accepted.
- Throughput: 1 push and 1 pop per cycle sustained when the queue is neither full nor empty.
- `pop_ready`, `push_valid` and `flush` have no combinational path to `push_ready` or `pop_valid`.

## Test plan
- Reset, then push PCs 4, 8, 12 with `pop_ready`=0. Required: `count`=3, `almost_full`=1 (DEPTH=4), head `pop_pc`=4.
- Push 4 entries (PC 4..16) with `pop_ready`=0, then hold `push_valid`=1. Required: `push_ready`=0, `count` stays 4. Release `pop_ready` for one cycle. Required: `pop_pc`=8 next cycle and `push_ready`=1.
- Steady stream: push and pop every cycle for 20 cycles. Required: `count` constant at 1, and the popped PC sequence is 4, 8, … 80 in order across pointer wrap.
- With 3 entries held, assert `flush` together with `push_valid`=1 and `pop_ready`=1. Required: next cycle `count`=0, `pop_instr`=0, `flush_drops`=3, and the pushed entry is absent.
- Assert `rst` with 2 entries queued. Required: all outputs 0 next cycle and `flush_drops`=0. Deassert `rst`. Required: `push_ready`=1 the following cycle.
- 100 flushes of a full queue. Required: `flush_drops` saturates at 255.
